// File: rtl/cfg_chain_param.sv
// rtl/cfg_chain_param.sv - parametrised configuration shift chain with parity check and shadowed output
module cfg_chain_param #(
    parameter int               NBITS   = 48,
    parameter int               CNT_W   = $clog2(NBITS + 2),
    parameter logic [NBITS-1:0] RST_CFG = {NBITS{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prgm_b,
    input  logic             cb_prgm_b,
    input  logic             cb_prgm_b_in,
    input  logic             bit_in,
    output logic             bit_out,
    output logic [NBITS-1:0] cfg_out,
    output logic             cb_prgm_b_out,
    output logic             cfg_err,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NBITS-1:0]   shift_q, shift_d;
    logic [NBITS-1:0]   cfg_q, cfg_d;
    logic               par_q, par_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               shift_en;

    assign shift_en = !prgm_b && cb_prgm_b && cb_prgm_b_in;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        cfg_d   = cfg_q;
        par_d   = par_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (shift_en) begin
                    shift_d = {shift_q[NBITS-2:0], bit_in};
                    count_d = CNT_W'(1);
                    err_d   = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Abort has priority; a dropped select/handoff only pauses.
                if (prgm_b) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (shift_en) begin
                    if (count_q == CNT_W'(NBITS)) begin
                        par_d   = bit_in;
                        state_d = S_CHECK;
                    end else begin
                        shift_d = {shift_q[NBITS-2:0], bit_in};
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            S_CHECK: begin
                if (((^shift_q) ^ par_q) == 1'b0) begin
                    cfg_d   = shift_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                if (prgm_b) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (prgm_b) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            shift_q <= '0;
            cfg_q   <= RST_CFG;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            cfg_q   <= cfg_d;
            par_q   <= par_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bit_out       = shift_q[NBITS-1];
    assign cfg_out       = cfg_q;
    assign cb_prgm_b_out = done_q;
    assign cfg_err       = err_q;
    assign busy          = (state_q == S_SHIFT) || (state_q == S_CHECK);

endmodule

// File: tb/tb_cfg_chain_param.sv
// tb/tb_cfg_chain_param.sv - scoreboard bench for cfg_chain_param with a cascaded second tile
module tb_cfg_chain_param;

    localparam int NB = 48;

    logic          clk = 1'b0;
    logic          reset;
    logic          prgm_b, sel0, in0, sel1, bit_in;
    logic          bo0, bo1, done0, done1, err0, err1, busy0, busy1;
    logic [NB-1:0] cfg0, cfg1;

    always #5 clk = ~clk;

    cfg_chain_param #(.NBITS(NB)) u0 (
        .clk(clk), .reset(reset), .prgm_b(prgm_b), .cb_prgm_b(sel0),
        .cb_prgm_b_in(in0), .bit_in(bit_in), .bit_out(bo0), .cfg_out(cfg0),
        .cb_prgm_b_out(done0), .cfg_err(err0), .busy(busy0)
    );

    cfg_chain_param #(.NBITS(NB)) u1 (
        .clk(clk), .reset(reset), .prgm_b(prgm_b), .cb_prgm_b(sel1),
        .cb_prgm_b_in(done0), .bit_in(bit_in), .bit_out(bo1), .cfg_out(cfg1),
        .cb_prgm_b_out(done1), .cfg_err(err1), .busy(busy1)
    );

    typedef struct {
        int            tile;
        bit            pass;
        logic [NB-1:0] cfg;
        int            edge_n;
        logic          bo;
    } exp_t;

    exp_t          sbq[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            edge_cnt = 0;
    logic [NB-1:0] committed0, committed1;
    logic          pd0 = 1'b0, pd1 = 1'b0, pe0 = 1'b0, pe1 = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic ev_check(input int t, input logic [NB-1:0] cfg, input logic done,
                            input logic err, input logic busy, input logic bo);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("unexpected_completion", 64'(t), 64'hFF);
        end else begin
            e = sbq.pop_front();
            chk("tile", 64'(t), 64'(e.tile));
            chk("done_flag", {63'b0, done}, {63'b0, e.pass});
            chk("err_flag", {63'b0, err}, {63'b0, !e.pass});
            chk("cfg_out", 64'(cfg), 64'(e.cfg));
            chk("commit_edge", 64'(edge_cnt), 64'(e.edge_n));
            chk("busy_after", {63'b0, busy}, 64'b0);
            chk("bit_out", {63'b0, bo}, {63'b0, e.bo});
        end
    endtask

    // Monitor: a rising done or error flag marks a completed load.
    always @(negedge clk) begin
        if (!reset) begin
            if ((done0 && !pd0) || (err0 && !pe0)) ev_check(0, cfg0, done0, err0, busy0, bo0);
            if ((done1 && !pd1) || (err1 && !pe1)) ev_check(1, cfg1, done1, err1, busy1, bo1);
        end
        pd0 <= done0; pd1 <= done1; pe0 <= err0; pe1 <= err1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 150 && sbq.size() != 0; k++) tick();
        if (sbq.size() != 0) begin
            chk("completion_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    task automatic do_load(input logic [NB-1:0] w, input logic par, input int pause_at,
                           input int pause_len, input bit use_sel);
        int   e0 = 0;
        int   np = 0;
        exp_t e;
        prgm_b = 1'b0; sel0 = 1'b1; in0 = 1'b1;
        for (int i = 0; i <= NB; i++) begin
            if (i == pause_at && pause_len > 0) begin
                if (use_sel) sel0 = 1'b0; else in0 = 1'b0;
                repeat (pause_len) begin
                    bit_in = 1'($urandom);
                    tick();
                end
                sel0 = 1'b1; in0 = 1'b1;
                np = pause_len;
            end
            bit_in = (i < NB) ? w[NB-1-i] : par;
            tick();
            if (i == 0) e0 = edge_cnt;
        end
        e.tile   = 0;
        e.pass   = ((^w) ^ par) == 1'b0;
        e.cfg    = e.pass ? w : committed0;
        e.edge_n = e0 + NB + 1 + np;
        e.bo     = w[NB-1];
        if (e.pass) committed0 = w;
        sbq.push_back(e);
        wait_drain();
        prgm_b = 1'b1;
        tick();
        chk("done_cleared", {63'b0, done0}, 64'b0);
        chk("idle_busy", {63'b0, busy0}, 64'b0);
        chk("err_sticky", {63'b0, err0}, {63'b0, !e.pass});
        chk("cfg_retained", 64'(cfg0), 64'(committed0));
    endtask

    task automatic partial(input logic [NB-1:0] w, input int nbits);
        prgm_b = 1'b0; sel0 = 1'b1; in0 = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            bit_in = w[NB-1-i];
            tick();
        end
    endtask

    task automatic cascade(input logic [NB-1:0] w0, input logic [NB-1:0] w1);
        int   e0 = 0;
        exp_t e;
        prgm_b = 1'b0; sel0 = 1'b1; in0 = 1'b1; sel1 = 1'b1;
        for (int i = 0; i < 2 * NB + 3; i++) begin
            if (i < NB)            bit_in = w0[NB-1-i];
            else if (i == NB)      bit_in = ^w0;
            else if (i == NB + 1)  bit_in = 1'($urandom);
            else if (i < 2*NB + 2) bit_in = w1[NB-1-(i-NB-2)];
            else                   bit_in = ^w1;
            tick();
            if (i == 0) e0 = edge_cnt;
            if (i == NB) begin
                e.tile = 0; e.pass = 1'b1; e.cfg = w0; e.edge_n = e0 + NB + 1; e.bo = w0[NB-1];
                sbq.push_back(e);
                chk("tile1_wait", {63'b0, busy1}, 64'b0);
            end
            if (i == NB + 1) chk("tile1_not_started", {63'b0, busy1}, 64'b0);
            if (i == NB + 2) chk("tile1_started", {63'b0, busy1}, 64'b1);
        end
        e.tile = 1; e.pass = 1'b1; e.cfg = w1; e.edge_n = e0 + 2 * NB + 3; e.bo = w1[NB-1];
        sbq.push_back(e);
        committed0 = w0;
        committed1 = w1;
        wait_drain();
        chk("tile1_done_end", {63'b0, done1}, 64'b1);
        chk("tile0_cfg_end", 64'(cfg0), 64'(w0));
        prgm_b = 1'b1; sel1 = 1'b0;
        tick();
    endtask

    initial begin
        logic [NB-1:0] gw;
        logic [63:0]   r;
        reset = 1'b1; prgm_b = 1'b1; sel0 = 1'b0; in0 = 1'b0; sel1 = 1'b0; bit_in = 1'b0;
        committed0 = '0; committed1 = '0;
        repeat (2) tick();
        chk("rst_cfg", 64'(cfg0), 64'd0);
        chk("rst_done", {63'b0, done0}, 64'b0);
        chk("rst_err", {63'b0, err0}, 64'b0);
        chk("rst_busy", {63'b0, busy0}, 64'b0);
        chk("rst_bit_out", {63'b0, bo0}, 64'b0);
        chk("rst_cfg1", 64'(cfg1), 64'd0);
        reset = 1'b0;
        tick();

        gw = 48'hA5A5_F00F_1234;
        do_load(gw, 1'b1, 0, 0, 1'b0);
        do_load(gw, 1'b0, 0, 0, 1'b0);
        do_load(gw ^ 48'h1, 1'b0, 0, 0, 1'b0);
        do_load(gw, 1'b1, 20, 5, 1'b0);

        partial(48'h0123_4567_89AB, 30);
        prgm_b = 1'b1;
        tick();
        chk("abort_busy", {63'b0, busy0}, 64'b0);
        chk("abort_cfg", 64'(cfg0), 64'(committed0));
        do_load(48'h0123_4567_89AB, 1'b1, 0, 0, 1'b0);

        partial(48'hFFFF_0000_FFFF, 10);
        prgm_b = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        committed0 = '0;
        chk("mid_rst_cfg", 64'(cfg0), 64'd0);
        chk("mid_rst_busy", {63'b0, busy0}, 64'b0);
        chk("mid_rst_done", {63'b0, done0}, 64'b0);
        chk("mid_rst_err", {63'b0, err0}, 64'b0);
        chk("mid_rst_bit_out", {63'b0, bo0}, 64'b0);
        tick();

        cascade(gw, 48'h5A5A_0FF0_EDCB);

        for (int n = 0; n < 8; n++) begin
            r  = {$urandom(), $urandom()};
            gw = r[NB-1:0];
            do_load(gw, (^gw) ^ ($urandom_range(0, 3) == 0), $urandom_range(1, NB - 1),
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
